// File: rtl/playfield_line_clear.sv
// Line-clear engine: registers the playfield, detects full rows on a lock event,
// flashes them, then collapses the board one row shift per cycle.
package DisplayPkg;
  localparam int PLAYFIELD_ROWS = 20;
  localparam int PLAYFIELD_COLS = 10;

  typedef enum logic [3:0] {
    BLANK  = 4'd0,
    GHOST  = 4'd1,
    TILE_I = 4'd2,
    TILE_O = 4'd3,
    TILE_T = 4'd4,
    TILE_S = 4'd5,
    TILE_Z = 4'd6,
    TILE_J = 4'd7,
    TILE_L = 4'd8
  } tile_type_t;

  typedef tile_type_t [PLAYFIELD_COLS-1:0] row_t;
  typedef row_t [PLAYFIELD_ROWS-1:0] board_t;

  function automatic row_t blank_row();
    row_t row;
    for (int c = 0; c < PLAYFIELD_COLS; c++) row[c] = BLANK;
    return row;
  endfunction

  function automatic board_t blank_board();
    board_t b;
    for (int r = 0; r < PLAYFIELD_ROWS; r++) b[r] = blank_row();
    return b;
  endfunction

  // GHOST is the drop preview, not a locked tile, so it never completes a row.
  function automatic logic row_full(input row_t row);
    logic full;
    full = 1'b1;
    for (int c = 0; c < PLAYFIELD_COLS; c++)
      if (row[c] == BLANK || row[c] == GHOST) full = 1'b0;
    return full;
  endfunction
endpackage

module playfield_line_clear
  import DisplayPkg::*;
#(
  parameter int FLASH_PERIOD  = 1_250_000,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  board_t     locked_tiles,
  output board_t     tile_type,
  output logic       busy,
  output logic       done,
  output logic [2:0] lines_cleared,
  output logic [2:0] state_dbg
);
  localparam int ROWS  = PLAYFIELD_ROWS;
  localparam int CNT_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int TOG_W = $clog2(FLASH_TOGGLES + 2);
  localparam int PTR_W = $clog2(ROWS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    FLASH    = 3'd2,
    COLLAPSE = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  board_t           board;
  logic [ROWS-1:0]  full_mask, full_now;
  logic [4:0]       full_cnt;
  logic [CNT_W-1:0] flash_cnt;
  logic [TOG_W-1:0] tog_cnt;
  logic             phase;
  logic [PTR_W-1:0] ptr;
  logic             flash_wrap, last_toggle;

  always_comb begin
    full_now = '0;
    full_cnt = '0;
    for (int r = 0; r < ROWS; r++) begin
      full_now[r] = row_full(board[r]);
      full_cnt    = full_cnt + 5'(full_now[r]);
    end
  end

  assign flash_wrap  = (flash_cnt == CNT_W'(FLASH_PERIOD - 1));
  assign last_toggle = (tog_cnt == TOG_W'(FLASH_TOGGLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SCAN;
      SCAN: begin
        if (full_now == '0)          state_nxt = DONE;
        else if (FLASH_TOGGLES == 0) state_nxt = COLLAPSE;
        else                         state_nxt = FLASH;
      end
      FLASH:    if (flash_wrap && last_toggle) state_nxt = COLLAPSE;
      COLLAPSE: if (!full_mask[ptr] && ptr == '0) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board         <= blank_board();
      full_mask     <= '0;
      lines_cleared <= '0;
      flash_cnt     <= '0;
      tog_cnt       <= '0;
      phase         <= 1'b0;
      ptr           <= '0;
    end else begin
      case (state)
        IDLE: board <= locked_tiles;
        SCAN: begin
          full_mask     <= full_now;
          lines_cleared <= full_cnt[2:0];
          ptr           <= PTR_W'(ROWS - 1);
          flash_cnt     <= '0;
          tog_cnt       <= '0;
          phase         <= 1'b0;
        end
        FLASH: begin
          if (flash_wrap) begin
            flash_cnt <= '0;
            tog_cnt   <= tog_cnt + 1'b1;
            phase     <= last_toggle ? 1'b0 : ~phase;
          end else begin
            flash_cnt <= flash_cnt + 1'b1;
          end
        end
        COLLAPSE: begin
          // A full row at ptr is overwritten by the rows above it; ptr stays put
          // so the row that dropped into place is evaluated next cycle.
          if (full_mask[ptr]) begin
            for (int r = 1; r < ROWS; r++) begin
              if (r <= int'(ptr)) begin
                board[r]     <= board[r-1];
                full_mask[r] <= full_mask[r-1];
              end
            end
            board[0]     <= blank_row();
            full_mask[0] <= 1'b0;
          end else if (ptr != '0) begin
            ptr <= ptr - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tile_type = board;
    if (state == FLASH && phase)
      for (int r = 0; r < ROWS; r++)
        if (full_mask[r]) tile_type[r] = blank_row();
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;
endmodule

// File: tb/tb_playfield_line_clear.sv
// Directed bench for playfield_line_clear: one instance without flash, one with
// a short flash (period 2, 4 toggles), checked against hand-built boards.
module tb_playfield_line_clear;
  import DisplayPkg::*;

  logic       clk;
  logic       rst;
  logic       start_nf, start_fl;
  board_t     lt;
  board_t     tile_nf, tile_fl;
  logic       busy_nf, busy_fl, done_nf, done_fl;
  logic [2:0] lines_nf, lines_fl, state_nf, state_fl;

  int n_vec  = 0;
  int n_miss = 0;

  playfield_line_clear #(.FLASH_PERIOD(2), .FLASH_TOGGLES(0)) dut_nf (
    .clk(clk), .rst(rst), .start(start_nf), .locked_tiles(lt),
    .tile_type(tile_nf), .busy(busy_nf), .done(done_nf),
    .lines_cleared(lines_nf), .state_dbg(state_nf)
  );

  playfield_line_clear #(.FLASH_PERIOD(2), .FLASH_TOGGLES(4)) dut_fl (
    .clk(clk), .rst(rst), .start(start_fl), .locked_tiles(lt),
    .tile_type(tile_fl), .busy(busy_fl), .done(done_fl),
    .lines_cleared(lines_fl), .state_dbg(state_fl)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic row_t fill_row(input tile_type_t t);
    row_t row;
    for (int c = 0; c < PLAYFIELD_COLS; c++) row[c] = t;
    return row;
  endfunction

  function automatic row_t one_tile(input int col, input tile_type_t t);
    row_t row;
    row = blank_row();
    row[col] = t;
    return row;
  endfunction

  // driver: pulse start on the selected instance, count cycles until done
  task automatic run_clear(input bit sel, output int cyc);
    if (sel) start_fl = 1'b1; else start_nf = 1'b1;
    tick();
    start_fl = 1'b0;
    start_nf = 1'b0;
    check("busy_in_scan", 64'(sel ? busy_fl : busy_nf), 64'd1);
    cyc = 1;
    while (!(sel ? done_fl : done_nf) && cyc < 80) begin
      tick();
      cyc++;
    end
    check("done_seen", 64'(sel ? done_fl : done_nf), 64'd1);
  endtask

  task automatic check_board_nf(input string tag, input board_t exp);
    for (int r = 0; r < PLAYFIELD_ROWS; r++)
      check($sformatf("%s_row%0d", tag, r), 64'(tile_nf[r]), 64'(exp[r]));
  endtask

  initial begin
    board_t exp_b;
    int     cyc;
    bit     seen_done;

    rst = 1'b1; start_nf = 1'b1; start_fl = 1'b1;
    lt  = blank_board();
    lt[19] = fill_row(TILE_T);
    lt[3]  = one_tile(2, TILE_S);

    // reset held 2 cycles with start asserted: stays IDLE, board blank
    tick(); tick();
    check("rst_state_nf", 64'(state_nf), 64'd0);
    check("rst_state_fl", 64'(state_fl), 64'd0);
    check("rst_busy", 64'(busy_nf), 64'd0);
    check("rst_done", 64'(done_nf), 64'd0);
    check("rst_lines", 64'(lines_nf), 64'd0);
    check_board_nf("rst_blank", blank_board());
    start_nf = 1'b0; start_fl = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_track_row19", 64'(tile_nf[19]), 64'(fill_row(TILE_T)));
    check("idle_not_busy", 64'(busy_nf), 64'd0);

    // no full rows: 9 T tiles, col 9 blank
    lt = blank_board();
    lt[19] = fill_row(TILE_T);
    lt[19][9] = BLANK;
    exp_b = lt;
    run_clear(1'b0, cyc);
    check("nofull_latency", 64'(cyc), 64'd2);
    check("nofull_lines", 64'(lines_nf), 64'd0);
    check_board_nf("nofull", exp_b);
    tick();
    check("nofull_idle", 64'(busy_nf), 64'd0);

    // ghost does not complete a row
    lt = blank_board();
    lt[19] = fill_row(TILE_Z);
    lt[19][4] = GHOST;
    exp_b = lt;
    run_clear(1'b0, cyc);
    check("ghost_latency", 64'(cyc), 64'd2);
    check("ghost_lines", 64'(lines_nf), 64'd0);
    check("ghost_row19", 64'(tile_nf[19]), 64'(exp_b[19]));
    tick();

    // single line: SCAN + 21 collapse cycles + DONE
    lt = blank_board();
    lt[19] = fill_row(TILE_L);
    lt[18] = one_tile(0, TILE_I);
    exp_b = blank_board();
    exp_b[19] = one_tile(0, TILE_I);
    run_clear(1'b0, cyc);
    check("single_latency", 64'(cyc), 64'd23);
    check("single_lines", 64'(lines_nf), 64'd1);
    check_board_nf("single", exp_b);
    tick();

    // tetris: rows 16..19 full
    lt = blank_board();
    lt[16] = fill_row(TILE_I);
    lt[17] = fill_row(TILE_J);
    lt[18] = fill_row(TILE_S);
    lt[19] = fill_row(TILE_O);
    lt[19][0] = TILE_T;
    lt[15] = one_tile(5, TILE_O);
    exp_b = blank_board();
    exp_b[19] = one_tile(5, TILE_O);
    run_clear(1'b0, cyc);
    check("tetris_latency", 64'(cyc), 64'd26);
    check("tetris_lines", 64'(lines_nf), 64'd4);
    check_board_nf("tetris", exp_b);
    tick();

    // split rows 17 and 19
    lt = blank_board();
    lt[19] = fill_row(TILE_Z);
    lt[18] = one_tile(2, TILE_J);
    lt[18][7] = TILE_S;
    lt[17] = fill_row(TILE_L);
    lt[16] = one_tile(0, TILE_T);
    exp_b = blank_board();
    exp_b[19] = one_tile(2, TILE_J);
    exp_b[19][7] = TILE_S;
    exp_b[18] = one_tile(0, TILE_T);
    run_clear(1'b0, cyc);
    check("split_latency", 64'(cyc), 64'd24);
    check("split_lines", 64'(lines_nf), 64'd2);
    check_board_nf("split", exp_b);
    tick();

    // flash instance: row 19 shows orig,orig,blank,blank,orig,orig,blank,blank
    lt = blank_board();
    lt[19] = fill_row(TILE_L);
    lt[18] = one_tile(0, TILE_I);
    start_fl = 1'b1;
    tick();
    start_fl = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("flash_row19_c%0d", i), 64'(tile_fl[19]),
            ((i / 2) % 2 == 1) ? 64'(blank_row()) : 64'(fill_row(TILE_L)));
      check($sformatf("flash_row18_c%0d", i), 64'(tile_fl[18]), 64'(one_tile(0, TILE_I)));
      tick();
    end
    check("flash_to_collapse", 64'(state_fl), 64'd3);
    cyc = 10;
    while (!done_fl && cyc < 80) begin
      tick();
      cyc++;
    end
    check("flash_latency", 64'(cyc), 64'd31);
    check("flash_lines", 64'(lines_fl), 64'd1);
    check("flash_final_row19", 64'(tile_fl[19]), 64'(one_tile(0, TILE_I)));
    check("flash_final_row18", 64'(tile_fl[18]), 64'(blank_row()));
    tick();

    // reset during COLLAPSE aborts at once
    start_fl = 1'b1;
    tick();
    start_fl = 1'b0;
    cyc = 0;
    while (state_fl != 3'd3 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("reach_collapse", 64'(state_fl), 64'd3);
    rst = 1'b1;
    tick();
    check("abort_state", 64'(state_fl), 64'd0);
    check("abort_busy", 64'(busy_fl), 64'd0);
    check("abort_lines", 64'(lines_fl), 64'd0);
    for (int r = 0; r < PLAYFIELD_ROWS; r++)
      check($sformatf("abort_row%0d", r), 64'(tile_fl[r]), 64'(blank_row()));
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done_fl) seen_done = 1'b1;
      tick();
    end
    check("abort_no_done", 64'(seen_done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
